cnet_reg_arbiter: RTL and testbench
===================================

# cnet_reg_arbiter

Shares the CPCI-to-CNET register request port among `NUM_REQ` pclk-domain requesters, for example the PCI target register decoder and the CNET programming/DMA engine. It round-robin arbitrates requests onto the `p2n_*` port and throttles on FIFO almost-full. It caps outstanding reads at two, the depth of the CNET-side result double buffer. Each returning `n2p_rd_rdy` result or `cnet_rd_timeout` is routed back to the requester that issued the read. The block sits between the requesters and `cnet_reg_iface`, entirely in the pclk domain.

## Interface
- `NUM_REQ`, default 2: number of requesters; 2 to 4.
- `ADDR_WIDTH`, default `` `CPCI_CNET_ADDR_WIDTH ``: CNET address width.
- `DATA_WIDTH`, default `` `CPCI_CNET_DATA_WIDTH `` (32): CNET data width.
- `MAX_RD`, default 2: outstanding read limit; fixed at 2.
- Clocking and reset: one clock; reset is synchronous and active-high.

Ports:
- `pclk`  in  1  PCI clock.
- `reset`  in  1  sync active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `req_ack`  out  NUM_REQ  combinational one-hot grant; the request is accepted this cycle.
- `rd_done`  out  NUM_REQ  one-hot registered read-completion pulse.
- `rd_err`  out  NUM_REQ  accompanies `rd_done`; read timed out or was flushed.
- `rd_data`  out  DATA_WIDTH  read data, valid with `rd_done`.
- `p2n_req`, `p2n_we`  out  1  registered FIFO write and type.
- `p2n_addr`  out  ADDR_WIDTH  registered FIFO address.
- `p2n_data`  out  DATA_WIDTH  registered FIFO data.
- `p2n_full`, `p2n_almost_full`  in  1  FIFO status.
- `n2p_data`  in  DATA_WIDTH  returned read data.
- `n2p_rd_rdy`  in  1  read result strobe.
- `cnet_rd_timeout`  in  1  timeout pulse.
- `cnet_reprog`  in  1  CNET reprogramming in progress.
- `busy`  out  1  `p2n_req` high, or any read outstanding.

## Operation
- **FSM states.**
  - RUN: normal arbitration.
  - FLUSH: entered whenever `cnet_reprog` = 1. Exits to RUN when `cnet_reprog` = 0 and the tag FIFO is empty.
- **Grant eligibility.** Requester i is eligible when all of the following hold:
  - state is RUN and `req_valid[i]` = 1;
  - `p2n_full` = 0 and `p2n_almost_full` = 0;
  - for a read, fewer than 2 reads are outstanding.
- **Round-robin.**
  - The search starts at index `last_grant+1` and wraps at `NUM_REQ`.
  - The pointer updates only on a grant.
  - On reset, `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
  - An ineligible read does not block an eligible write from another requester.
- **Handshake.** The requester holds its fields stable until `req_ack`. On the cycle after `req_ack` it may present a new request or drop `req_valid`.
- **Read tracking.**
  - Each granted read pushes {requester index, err = 0} into the tag FIFO.
  - A `cnet_rd_timeout` pulse sets err on the head entry.
  - On `n2p_rd_rdy`, the head entry pops. `rd_done[idx]` pulses with `rd_data = n2p_data`, and `rd_err[idx]` = head.err OR a timeout in the same cycle.
  - `n2p_rd_rdy` or `cnet_rd_timeout` with the tag FIFO empty is ignored.
  - A push and a pop in the same cycle are both performed.
- **FLUSH behaviour.**
  - No grants.
  - One entry is retired per cycle with `rd_done` and `rd_err` set and `rd_data` = 32'hdead_beef.
  - `n2p_rd_rdy` is ignored while in FLUSH.
- **Reset values.**
  - All registered outputs are 0.
  - Tag FIFO empty, state RUN.
  - Outstanding reads are discarded without a `rd_done`.
  - Reset overrides everything, including mid-flush.

## Timing
- Grant in cycle N, so `req_ack` is high in N. The corresponding `p2n_req` is high in N+1 for exactly one cycle.
- Throughput is at most one grant per cycle.
- Gating on almost-full covers the one-cycle registration slack.
- Result path: `n2p_rd_rdy` in cycle M gives `rd_done` and `rd_data` in M+1.
- The 3rd read stalls until the pop cycle. A pop in cycle M frees a slot for a grant in M.
- FLUSH retires entry k in cycle F+k, where F is the first FLUSH cycle after `cnet_reprog` is seen. `rd_done` follows one cycle later.

## Structure
- Shared package/defines `cnet_arb_defs`:
  - `CNET_ARB_MAX_RD` = 2
  - `CNET_ARB_DEADBEEF` = 32'hdead_beef
  - state encodings RUN = 1'b0, FLUSH = 1'b1
  - tag entry layout {err, idx[1:0]}
- Sub-module `cnet_rd_tag_fifo`: 2-entry FIFO.
  - Simultaneous push/pop.
  - Head err-set port.
  - Outputs `count[1:0]`, `empty`, `full`.

## Test plan
- **Round-robin fairness.** Requesters 0 and 1 both hold writes, addr 0x10 and 0x20. Required: `req_ack` alternates 01, 10, 01; `p2n_addr` sequence 0x10, 0x20, 0x10, each one cycle after its ack.
- **Backpressure.** Raise `p2n_almost_full` for 5 cycles with requests pending. Required: no `req_ack` and no `p2n_req` during the window; resume on the first cycle it drops.
- **Read limit.** Requester 0 issues 3 reads. Required: the third stalls. `n2p_rd_rdy` with data 0x12345678 gives `rd_done[0]` and that data one cycle later, and the third read is acked the same cycle as the pop.
- **Return routing.** Requester 1 reads, then requester 0 reads. Returns 0xA, 0xB. Required: `rd_done[1]` with 0xA, then `rd_done[0]` with 0xB.
- **Timeout.** `cnet_rd_timeout` pulses, then `n2p_rd_rdy` arrives with 0xdeadbeef. Required: `rd_done` with `rd_err` set for the owner.
- **Reprogram mid-operation.** Two reads outstanding; assert `cnet_reprog`. Required: two consecutive `rd_done` + `rd_err` pulses with 0xdeadbeef, no grants while `cnet_reprog` is high, RUN resumed after it falls.

Source files
------------

// File: rtl/cnet_reg_arbiter_pkg.sv
// Shared definitions for the CNET register request arbiter: widths, limits,
// FSM state encoding and the read-tag entry layout.
package cnet_arb_defs;

  localparam int unsigned CPCI_CNET_ADDR_WIDTH = 27;
  localparam int unsigned CPCI_CNET_DATA_WIDTH = 32;
  localparam int unsigned CNET_ARB_MAX_RD      = 2;
  localparam logic [31:0] CNET_ARB_DEADBEEF    = 32'hdead_beef;

  typedef enum logic {
    ARB_RUN   = 1'b0,
    ARB_FLUSH = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       err;
    logic [1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/cnet_reg_arbiter_if.sv
// CPCI-to-CNET register port as seen by the arbiter (master) and by
// cnet_reg_iface (slave), including the read-return and reprogram status.
interface cnet_reg_arbiter_if import cnet_arb_defs::*; #(
  parameter int unsigned ADDR_WIDTH = CPCI_CNET_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CPCI_CNET_DATA_WIDTH
);
  logic                  p2n_req;
  logic                  p2n_we;
  logic [ADDR_WIDTH-1:0] p2n_addr;
  logic [DATA_WIDTH-1:0] p2n_data;
  logic                  p2n_full;
  logic                  p2n_almost_full;
  logic [DATA_WIDTH-1:0] n2p_data;
  logic                  n2p_rd_rdy;
  logic                  cnet_rd_timeout;
  logic                  cnet_reprog;

  modport master (
    output p2n_req, p2n_we, p2n_addr, p2n_data,
    input  p2n_full, p2n_almost_full, n2p_data, n2p_rd_rdy,
           cnet_rd_timeout, cnet_reprog
  );

  modport slave (
    input  p2n_req, p2n_we, p2n_addr, p2n_data,
    output p2n_full, p2n_almost_full, n2p_data, n2p_rd_rdy,
           cnet_rd_timeout, cnet_reprog
  );
endinterface

// File: rtl/cnet_reg_arbiter_rd_tag_fifo.sv
// Two-entry FIFO of outstanding read tags {err, idx}; supports push and pop in
// the same cycle and marking the head entry as errored.
module cnet_rd_tag_fifo import cnet_arb_defs::*; (
  input  logic       pclk,
  input  logic       reset,
  input  logic       push,
  input  rd_tag_t    push_tag,
  input  logic       pop,
  input  logic       set_err,
  output rd_tag_t    head,
  output logic [1:0] count,
  output logic       empty,
  output logic       full
);

  rd_tag_t    mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge pclk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (set_err && !empty)
        mem[rd_ptr].err <= 1'b1;
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cnet_reg_arbiter.sv
// Round-robin arbiter sharing the CPCI-to-CNET register port among NUM_REQ
// pclk-domain requesters, with read-result routing and reprogram flushing.
module cnet_reg_arbiter import cnet_arb_defs::*; #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = CPCI_CNET_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CPCI_CNET_DATA_WIDTH,
  parameter int unsigned MAX_RD     = CNET_ARB_MAX_RD
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            rd_done,
  output logic [NUM_REQ-1:0]            rd_err,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          busy,
  cnet_reg_arbiter_if.master            cnet
);

  arb_state_e            state, state_nxt;
  logic [1:0]            last_grant;
  logic [NUM_REQ-1:0]    eligible;
  logic                  grant_ok;
  logic                  read_ok;
  logic                  grant_any;
  logic [1:0]            grant_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  run_pop;
  logic                  flush_pop;
  logic                  pop;
  logic [NUM_REQ-1:0]    done_nxt;
  logic [NUM_REQ-1:0]    err_nxt;

  rd_tag_t               fifo_head;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;

  cnet_rd_tag_fifo u_tag_fifo (
    .pclk     (pclk),
    .reset    (reset),
    .push     (grant_any && !sel_we),
    .push_tag ('{err: 1'b0, idx: grant_idx}),
    .pop      (pop),
    .set_err  ((state == ARB_RUN) && cnet.cnet_rd_timeout),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign run_pop   = (state == ARB_RUN) && cnet.n2p_rd_rdy && !fifo_empty;
  assign flush_pop = (state == ARB_FLUSH) && !fifo_empty;
  assign pop       = run_pop || flush_pop;
  // A pop this cycle frees a slot that a read may claim in the same cycle.
  assign read_ok   = (!fifo_full && (fifo_count < 2'(MAX_RD))) || run_pop;
  assign grant_ok  = (state == ARB_RUN) && !cnet.cnet_reprog &&
                     !cnet.p2n_full && !cnet.p2n_almost_full;
  assign busy      = cnet.p2n_req || (fifo_count != 2'd0);

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++)
      eligible[i] = grant_ok && req_valid[i] && (req_we[i] || read_ok);
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    req_ack   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && eligible[i] && (((32'(last_grant) + k) % NUM_REQ) == i)) begin
          grant_any = 1'b1;
          grant_idx = 2'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == 2'(i))) begin
        req_ack[i] = 1'b1;
        sel_we     = req_we[i];
        sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    done_nxt = '0;
    err_nxt  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pop && (fifo_head.idx == 2'(i))) begin
        done_nxt[i] = 1'b1;
        err_nxt[i]  = flush_pop || fifo_head.err || cnet.cnet_rd_timeout;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_RUN:   if (cnet.cnet_reprog) state_nxt = ARB_FLUSH;
      ARB_FLUSH: if (!cnet.cnet_reprog && fifo_empty) state_nxt = ARB_RUN;
      default:   state_nxt = ARB_RUN;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state         <= ARB_RUN;
      last_grant    <= 2'(NUM_REQ - 1);
      cnet.p2n_req  <= 1'b0;
      cnet.p2n_we   <= 1'b0;
      cnet.p2n_addr <= '0;
      cnet.p2n_data <= '0;
      rd_done       <= '0;
      rd_err        <= '0;
      rd_data       <= '0;
    end else begin
      state        <= state_nxt;
      cnet.p2n_req <= grant_any;
      if (grant_any) begin
        last_grant    <= grant_idx;
        cnet.p2n_we   <= sel_we;
        cnet.p2n_addr <= sel_addr;
        cnet.p2n_data <= sel_data;
      end
      rd_done <= done_nxt;
      rd_err  <= err_nxt;
      if (pop)
        rd_data <= flush_pop ? DATA_WIDTH'(CNET_ARB_DEADBEEF) : cnet.n2p_data;
    end
  end

endmodule

// File: tb/tb_cnet_reg_arbiter.sv
// Bench for cnet_reg_arbiter: directed scenarios with literal expectations plus
// a queue-based model compared against the DUT on every falling edge.
module tb_cnet_reg_arbiter;
  import cnet_arb_defs::*;

  localparam int N  = 2;
  localparam int AW = 27;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid, req_we, req_ack, rd_done, rd_err;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rd_data;
  logic            busy;

  int checks = 0;
  int errors = 0;

  cnet_reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cnet ();

  cnet_reg_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RD(2)) dut (
    .pclk      (pclk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .rd_done   (rd_done),
    .rd_err    (rd_err),
    .rd_data   (rd_data),
    .busy      (busy),
    .cnet      (cnet)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_last = N - 1;
  int            q_idx[$];
  bit            q_err[$];
  bit            m_flush = 1'b0;
  logic          exp_req = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_pdata = '0, exp_rdata = '0;
  logic [N-1:0]  exp_done = '0, exp_err = '0;

  always @(negedge pclk) begin : model
    logic [N-1:0] ack;
    int g, sz, cand;
    ack = '0;
    g   = -1;
    sz  = q_idx.size();
    if (!reset && !m_flush && !cnet.cnet_reprog && !cnet.p2n_full && !cnet.p2n_almost_full) begin
      for (int k = 1; k <= N; k++) begin
        cand = (m_last + k) % N;
        if (g < 0 && req_valid[cand] &&
            (req_we[cand] || sz < 2 || (cnet.n2p_rd_rdy && sz > 0)))
          g = cand;
      end
    end
    if (g >= 0) ack[g] = 1'b1;

    if (!reset) chk("m_req_ack", req_ack, ack);
    chk("m_p2n_req", cnet.p2n_req, exp_req);
    chk("m_p2n_we", cnet.p2n_we, exp_we);
    chk("m_p2n_addr", cnet.p2n_addr, exp_addr);
    chk("m_p2n_data", cnet.p2n_data, exp_pdata);
    chk("m_rd_done", rd_done, exp_done);
    chk("m_rd_err", rd_err, exp_err);
    chk("m_rd_data", rd_data, exp_rdata);
    chk("m_busy", busy, exp_req || (sz > 0));

    if (reset) begin
      m_last = N - 1; q_idx.delete(); q_err.delete(); m_flush = 1'b0;
      exp_req = 0; exp_we = 0; exp_addr = '0; exp_pdata = '0;
      exp_rdata = '0; exp_done = '0; exp_err = '0;
    end else begin
      exp_req = (g >= 0);
      if (g >= 0) begin
        m_last    = g;
        exp_we    = req_we[g];
        exp_addr  = req_addr[g*AW +: AW];
        exp_pdata = req_data[g*DW +: DW];
      end
      exp_done = '0;
      exp_err  = '0;
      if (m_flush) begin
        if (sz > 0) begin
          exp_done[q_idx[0]] = 1'b1;
          exp_err[q_idx[0]]  = 1'b1;
          exp_rdata = 32'hdeadbeef;
          void'(q_idx.pop_front()); void'(q_err.pop_front());
        end
      end else if (sz > 0) begin
        if (cnet.n2p_rd_rdy) begin
          exp_done[q_idx[0]] = 1'b1;
          exp_err[q_idx[0]]  = q_err[0] | cnet.cnet_rd_timeout;
          exp_rdata = cnet.n2p_data;
          void'(q_idx.pop_front()); void'(q_err.pop_front());
        end else if (cnet.cnet_rd_timeout) begin
          q_err[0] = 1'b1;
        end
      end
      if (g >= 0 && !req_we[g]) begin
        q_idx.push_back(g);
        q_err.push_back(1'b0);
      end
      if (cnet.cnet_reprog) m_flush = 1'b1;
      else if (m_flush && sz == 0) m_flush = 1'b0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_data = '0;
    cnet.p2n_full = 0; cnet.p2n_almost_full = 0; cnet.n2p_data = '0;
    cnet.n2p_rd_rdy = 0; cnet.cnet_rd_timeout = 0; cnet.cnet_reprog = 0;
    repeat (3) tick();
    reset = 1'b0;
    #2;
    chk("rst_p2n_req", cnet.p2n_req, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", req_ack, 0);

    // Round-robin between two writers
    tick();
    req_addr = {27'h20, 27'h10}; req_data = {32'hD1, 32'hD0};
    req_we = 2'b11; req_valid = 2'b11;
    #2 chk("rr_ack_a", req_ack, 2'b01);
    tick(); #2;
    chk("rr_ack_b", req_ack, 2'b10); chk("rr_addr_a", cnet.p2n_addr, 'h10); chk("rr_req_a", cnet.p2n_req, 1);
    tick(); #2;
    chk("rr_ack_c", req_ack, 2'b01); chk("rr_addr_b", cnet.p2n_addr, 'h20);
    tick(); req_valid = 2'b00; #2;
    chk("rr_addr_c", cnet.p2n_addr, 'h10); chk("rr_ack_d", req_ack, 2'b00);
    tick(); #2 chk("rr_req_end", cnet.p2n_req, 0);

    // Almost-full backpressure
    for (int i = 0; i < 5; i++) begin
      tick(); cnet.p2n_almost_full = 1; req_valid = 2'b11; #2;
      chk("bp_ack", req_ack, 2'b00); chk("bp_p2n_req", cnet.p2n_req, 0);
    end
    tick(); cnet.p2n_almost_full = 0; #2 chk("bp_resume_ack", req_ack, 2'b10);
    tick(); req_valid = 2'b00; #2;
    chk("bp_resume_req", cnet.p2n_req, 1); chk("bp_resume_addr", cnet.p2n_addr, 'h20);

    // Read limit: third read stalls until a pop
    tick(); req_addr = {27'h20, 27'h30}; req_we = 2'b00; req_valid = 2'b01;
    #2 chk("rl_ack1", req_ack, 2'b01);
    tick(); #2 chk("rl_ack2", req_ack, 2'b01);
    tick(); #2 chk("rl_stall1", req_ack, 2'b00);
    tick(); #2 chk("rl_stall2", req_ack, 2'b00);
    tick(); cnet.n2p_rd_rdy = 1; cnet.n2p_data = 32'h12345678;
    #2 chk("rl_ack3_on_pop", req_ack, 2'b01);
    tick(); req_valid = 2'b00; cnet.n2p_data = 32'h11111111; #2;
    chk("rl_done", rd_done, 2'b01); chk("rl_data", rd_data, 32'h12345678); chk("rl_err", rd_err, 0);
    tick(); cnet.n2p_data = 32'h22222222; #2 chk("rl_data2", rd_data, 32'h11111111);
    tick(); cnet.n2p_rd_rdy = 0; #2;
    chk("rl_data3", rd_data, 32'h22222222); chk("rl_busy_clear", busy, 0);

    // Return routing
    tick(); req_valid = 2'b10; #2 chk("rt_ack1", req_ack, 2'b10);
    tick(); req_valid = 2'b01; #2 chk("rt_ack0", req_ack, 2'b01);
    tick(); req_valid = 2'b00; cnet.n2p_rd_rdy = 1; cnet.n2p_data = 32'hA;
    tick(); cnet.n2p_data = 32'hB; #2;
    chk("rt_done1", rd_done, 2'b10); chk("rt_data1", rd_data, 32'hA);
    tick(); cnet.n2p_rd_rdy = 0; #2;
    chk("rt_done0", rd_done, 2'b01); chk("rt_data0", rd_data, 32'hB);

    // Timeout marks the head entry
    tick(); req_valid = 2'b10; #2 chk("to_ack", req_ack, 2'b10);
    tick(); req_valid = 2'b00; cnet.cnet_rd_timeout = 1;
    tick(); cnet.cnet_rd_timeout = 0; cnet.n2p_rd_rdy = 1; cnet.n2p_data = 32'hdeadbeef;
    tick(); cnet.n2p_rd_rdy = 0; #2;
    chk("to_done", rd_done, 2'b10); chk("to_err", rd_err, 2'b10); chk("to_data", rd_data, 32'hdeadbeef);

    // Reprogram with two reads outstanding
    tick(); req_valid = 2'b11; #2 chk("rp_ack0", req_ack, 2'b01);
    tick(); #2 chk("rp_ack1", req_ack, 2'b10);
    tick(); cnet.cnet_reprog = 1; #2 chk("rp_nogrant_a", req_ack, 2'b00);
    tick(); #2 chk("rp_nogrant_b", req_ack, 2'b00);
    tick(); #2;
    chk("rp_done0", rd_done, 2'b01); chk("rp_err0", rd_err, 2'b01);
    chk("rp_data0", rd_data, 32'hdeadbeef); chk("rp_nogrant_c", req_ack, 2'b00);
    tick(); #2;
    chk("rp_done1", rd_done, 2'b10); chk("rp_err1", rd_err, 2'b10);
    chk("rp_data1", rd_data, 32'hdeadbeef); chk("rp_nogrant_d", req_ack, 2'b00);
    tick(); cnet.cnet_reprog = 0; req_valid = 2'b01;
    tick(); #2 chk("rp_run_ack", req_ack, 2'b01);
    tick(); req_valid = 2'b00; #2;
    chk("rp_run_p2n", cnet.p2n_req, 1); chk("rp_run_we", cnet.p2n_we, 0);

    // Reset during reprogram discards the outstanding read
    tick(); cnet.cnet_reprog = 1; reset = 1;
    tick(); cnet.cnet_reprog = 0; reset = 0; #2;
    chk("rs_done", rd_done, 0); chk("rs_busy", busy, 0);
    tick(); req_valid = 2'b01; #2 chk("rs_ack", req_ack, 2'b01);
    tick(); req_valid = 2'b00;
    tick(); cnet.n2p_rd_rdy = 1; cnet.n2p_data = 32'h5A5A5A5A;
    tick(); cnet.n2p_rd_rdy = 0; #2;
    chk("rs_done_after", rd_done, 2'b01); chk("rs_data_after", rd_data, 32'h5A5A5A5A);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
